// File: rtl/mem_bus_pkg.sv
// Shared types and sizes for the memory/IO bus sequencer.
// Holds the one-hot bus cycle states, the bus widths and the latched-request record.
package mem_bus_pkg;

    localparam int ADDR_W           = 20;
    localparam int DATA_W           = 8;
    localparam int WAIT_W           = 4;
    localparam int MAX_WAIT_DEFAULT = 15;

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        T1   = 5'b00010,
        T2   = 5'b00100,
        T3   = 5'b01000,
        T4   = 5'b10000
    } bus_state_t;

    // Everything captured from the winning requester at grant time
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic              iom;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// The pointer names the favoured requester and moves past the winner whenever a grant is taken.
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After serving requester 0 favour 1, and vice versa
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr <= 1'b0;
        end else if (enable && (grant != 2'b00)) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Two-master bus sequencer running classic T1..T4 memory/IO cycles.
// READY stretches T3 with wait states; the cycle is aborted once the wait budget runs out.
module mem_bus_sequencer
    import mem_bus_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [1:0]        req_we,
    input  logic [1:0]        req_iom,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    input  logic              READY,
    input  logic [DATA_W-1:0] Data_in,
    output logic              ALE,
    output logic              RD,
    output logic              WR,
    output logic              IOM,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe,
    output logic [1:0]        ack,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    bus_state_t        state;
    bus_state_t        next_state;
    bus_req_t          cur;
    logic              gnt_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              abort_q;

    logic [1:0]        arb_grant;
    logic              arb_en;
    logic              wait_inc;
    logic              abort_set;
    logic              rdata_load;
    logic              strobe_phase;
    logic              data_phase;

    rr_arbiter2 u_arb (
        .CLK    (CLK),
        .RESET  (RESET),
        .req    (req),
        .enable (arb_en),
        .grant  (arb_grant)
    );

    // Next-state logic; T3 either completes on READY or burns one wait state
    always_comb begin
        next_state = state;
        arb_en     = 1'b0;
        wait_inc   = 1'b0;
        abort_set  = 1'b0;
        rdata_load = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    arb_en     = 1'b1;
                    next_state = T1;
                end
            end
            T1: next_state = T2;
            T2: next_state = T3;
            T3: begin
                if (READY) begin
                    rdata_load = ~cur.we;
                    next_state = T4;
                end else if (wait_cnt >= WAIT_LIMIT) begin
                    abort_set  = 1'b1;
                    next_state = T4;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            T4:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus strobes and completion pulses are decoded straight from the state register
    always_comb begin
        strobe_phase = (state == T2) || (state == T3);
        data_phase   = strobe_phase || (state == T4);
        ALE          = (state == T1);
        RD           = ~(strobe_phase && ~cur.we);
        WR           = ~(strobe_phase && cur.we);
        Data_oe      = data_phase && cur.we;
        IOM          = cur.iom;
        Address      = cur.addr;
        Data_out     = cur.wdata;
        ack          = 2'b00;
        err          = 2'b00;
        if (state == T4) begin
            if (abort_q) begin
                err = gnt_idx ? 2'b10 : 2'b01;
            end else begin
                ack = gnt_idx ? 2'b10 : 2'b01;
            end
        end
    end

    // Cycle bookkeeping; the latched request stays put between cycles so Address holds
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            cur      <= '0;
            gnt_idx  <= 1'b0;
            wait_cnt <= '0;
            abort_q  <= 1'b0;
            rdata    <= '0;
        end else begin
            state <= next_state;
            if (arb_en) begin
                gnt_idx  <= arb_grant[1];
                wait_cnt <= '0;
                abort_q  <= 1'b0;
                if (arb_grant[0]) begin
                    cur <= '{addr: req_addr0, we: req_we[0], iom: req_iom[0], wdata: req_wdata0};
                end else begin
                    cur <= '{addr: req_addr1, we: req_we[1], iom: req_iom[1], wdata: req_wdata1};
                end
            end else if (wait_inc && (wait_cnt != {WAIT_W{1'b1}})) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (abort_set) begin
                abort_q <= 1'b1;
            end
            if (rdata_load) begin
                rdata <= Data_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Transaction-level bench for mem_bus_sequencer: tracks each granted cycle by its position
// relative to the grant and derives every expected bus output from that position.
module tb_mem_bus_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  req;
    logic [19:0] req_addr0, req_addr1;
    logic [1:0]  req_we, req_iom;
    logic [7:0]  req_wdata0, req_wdata1;
    logic        READY;
    logic [7:0]  Data_in;
    logic        ALE, RD, WR, IOM, Data_oe;
    logic [19:0] Address;
    logic [7:0]  Data_out, rdata;
    logic [1:0]  ack, err;

    int vectors = 0;
    int miscompares = 0;

    mem_bus_sequencer #(.MAX_WAIT(15)) dut (
        .CLK(CLK), .RESET(RESET), .req(req),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_we(req_we), .req_iom(req_iom),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .READY(READY), .Data_in(Data_in),
        .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM), .Address(Address),
        .Data_out(Data_out), .Data_oe(Data_oe),
        .ack(ack), .err(err), .rdata(rdata)
    );

    always #5 CLK = ~CLK;

    // Requests waiting for service, one slot per requester
    bit          pending[2];
    logic [19:0] pAddr[2];
    bit          pWe[2], pIom[2];
    logic [7:0]  pWdata[2], pRval[2];
    int          pWait[2];

    // Cycle in progress: c counts cycles since the grant edge (1 = T1)
    bit          busy;
    int          c, t4, g, lastG;
    bit          abortExp;
    logic [19:0] cAddr, expAddr;
    bit          cWe, cIom;
    logic [7:0]  cWdata, cRval, expRdata;
    int          cWait;
    bit          randomArrivals;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic postRequest(input int r, input logic [19:0] a, input bit we, input bit iom,
                               input logic [7:0] wd, input int w, input logic [7:0] rv);
        pending[r] = 1'b1;
        pAddr[r]   = a;
        pWe[r]     = we;
        pIom[r]    = iom;
        pWdata[r]  = wd;
        pWait[r]   = w;
        pRval[r]   = rv;
    endtask

    task automatic postRandom(input int r);
        int sel;
        int w;
        sel = $urandom_range(0, 11);
        if (sel == 11)     w = 16;
        else if (sel >= 9) w = 15;
        else               w = sel % 5;
        postRequest(r, 20'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), w, 8'($urandom));
    endtask

    task automatic applyStimulus();
        req        = {pending[1], pending[0]};
        req_addr0  = pending[0] ? pAddr[0]  : 20'($urandom);
        req_addr1  = pending[1] ? pAddr[1]  : 20'($urandom);
        req_we     = {pending[1] ? pWe[1]  : 1'($urandom), pending[0] ? pWe[0]  : 1'($urandom)};
        req_iom    = {pending[1] ? pIom[1] : 1'($urandom), pending[0] ? pIom[0] : 1'($urandom)};
        req_wdata0 = pending[0] ? pWdata[0] : 8'($urandom);
        req_wdata1 = pending[1] ? pWdata[1] : 8'($urandom);
    endtask

    // One clock: check the outputs of the current cycle, then drive inputs for its closing edge
    task automatic stepCycle();
        bit strobe;
        @(negedge CLK);
        checkOutput("strobe_excl", {31'd0, RD | WR}, 32'd1);
        checkOutput("rdata", rdata, expRdata);
        checkOutput("address", Address, expAddr);
        if (randomArrivals) begin
            for (int r = 0; r < 2; r++) begin
                if (!pending[r] && !(busy && g == r) && $urandom_range(0, 2) == 0) postRandom(r);
            end
        end
        READY   = 1'($urandom);
        Data_in = 8'($urandom);
        if (!busy) begin
            checkOutput("idle_ale", ALE, 0);
            checkOutput("idle_rdwr", {RD, WR}, 2'b11);
            checkOutput("idle_oe", Data_oe, 0);
            checkOutput("idle_ackerr", {ack, err}, 4'b0000);
            applyStimulus();
            if (pending[0] || pending[1]) begin
                if (pending[0] && pending[1]) g = 1 - lastG;
                else                          g = pending[0] ? 0 : 1;
                lastG    = g;
                busy     = 1'b1;
                c        = 1;
                cAddr    = pAddr[g];
                cWe      = pWe[g];
                cIom     = pIom[g];
                cWdata   = pWdata[g];
                cWait    = pWait[g];
                cRval    = pRval[g];
                abortExp = (cWait >= 16);
                t4       = abortExp ? 19 : 4 + cWait;
                expAddr  = cAddr;
            end
        end else begin
            strobe = (c >= 2) && (c < t4);
            checkOutput("ale", ALE, (c == 1));
            checkOutput("rd", RD, !(strobe && !cWe));
            checkOutput("wr", WR, !(strobe && cWe));
            checkOutput("data_oe", Data_oe, cWe && (c >= 2) && (c <= t4));
            checkOutput("iom", IOM, cIom);
            if (cWe && c >= 2) checkOutput("data_out", Data_out, cWdata);
            checkOutput("ack", ack, (c == t4 && !abortExp) ? (g == 0 ? 2'b01 : 2'b10) : 2'b00);
            checkOutput("err", err, (c == t4 && abortExp) ? (g == 0 ? 2'b01 : 2'b10) : 2'b00);
            if (c >= 3 && c < t4) begin
                READY = ((c - 3) >= cWait);
                if (READY) begin
                    Data_in = cRval;
                    if (!cWe) expRdata = cRval;
                end
            end
            if (c == t4) begin
                pending[g] = 1'b0;
                busy       = 1'b0;
            end
            c++;
            applyStimulus();
        end
    endtask

    task automatic runUntilIdle(input int budget);
        int n = 0;
        while ((busy || pending[0] || pending[1]) && n < budget) begin
            stepCycle();
            n++;
        end
        if (busy || pending[0] || pending[1]) checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ale"}, ALE, 0);
        checkOutput({tag, "_rdwr"}, {RD, WR}, 2'b11);
        checkOutput({tag, "_iom_oe"}, {IOM, Data_oe}, 2'b00);
        checkOutput({tag, "_addr"}, Address, 0);
        checkOutput({tag, "_dout"}, Data_out, 0);
        checkOutput({tag, "_rdata"}, rdata, 0);
        checkOutput({tag, "_ackerr"}, {ack, err}, 4'b0000);
    endtask

    task automatic modelReset();
        pending[0] = 1'b0;
        pending[1] = 1'b0;
        busy       = 1'b0;
        lastG      = 1;
        expRdata   = '0;
        expAddr    = '0;
    endtask

    initial begin
        randomArrivals = 1'b0;
        modelReset();
        RESET   = 1'b1;
        READY   = 1'b0;
        Data_in = '0;
        applyStimulus();
        repeat (2) @(negedge CLK);
        checkResetState("reset");
        RESET = 1'b0;

        postRequest(0, 20'h12345, 1'b0, 1'b0, 8'h00, 0, 8'hA5);
        runUntilIdle(50);
        postRequest(1, 20'h00FF0, 1'b1, 1'b1, 8'h3C, 0, 8'h00);
        runUntilIdle(50);
        postRequest(0, 20'hABCDE, 1'b0, 1'b0, 8'h00, 3, 8'h5A);
        runUntilIdle(50);
        postRequest(1, 20'h0F0F0, 1'b0, 1'b1, 8'h00, 16, 8'hEE);
        runUntilIdle(50);
        postRequest(0, 20'h11111, 1'b0, 1'b0, 8'h00, 15, 8'h77);
        postRequest(1, 20'h22222, 1'b1, 1'b0, 8'h99, 1, 8'h00);
        runUntilIdle(80);

        randomArrivals = 1'b1;
        for (int i = 0; i < 3000; i++) stepCycle();
        randomArrivals = 1'b0;
        runUntilIdle(100);

        // Reset in the middle of a read must leave no completion pulse behind
        postRequest(0, 20'h33333, 1'b0, 1'b0, 8'h00, 2, 8'h44);
        for (int n = 0; n < 20 && !(busy && c == 2); n++) stepCycle();
        if (!(busy && c == 2)) checkOutput("reach_t2", 0, 1);
        stepCycle();
        RESET      = 1'b1;
        pending[0] = 1'b0;
        applyStimulus();
        @(negedge CLK);
        checkResetState("midreset");
        @(negedge CLK);
        checkResetState("midreset2");
        modelReset();
        RESET = 1'b0;

        postRequest(1, 20'h44444, 1'b1, 1'b0, 8'h12, 0, 8'h00);
        postRequest(0, 20'h55555, 1'b0, 1'b0, 8'h00, 0, 8'h66);
        runUntilIdle(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_sequencer.md
MEM_BUS_SEQUENCER -- requirements
Module: mem_bus_sequencer

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum wait states inserted in T3 before a cycle is aborted.
REQ-002 CLK  input  1  system clock; all state changes on posedge CLK.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-004 req[1:0]  input  2  per-requester bus request; index 0 is CPU, index 1 is DMA; held high until ack.
REQ-005 req_addr0/req_addr1  input  20 each  requester byte address.
REQ-006 req_we[1:0], req_iom[1:0]  input  2 each  1=write / 1=IO space, per requester.
REQ-007 req_wdata0/req_wdata1  input  8 each  write data.
REQ-008 READY  input  1  target ready; low extends T3.
REQ-009 Data_in  input  8  read data from memory/IO target.
REQ-010 ALE  output  1  address latch enable, high only in T1.
REQ-011 RD, WR  output  1 each  active-low strobes.
REQ-012 IOM  output  1  1=IO cycle, 0=memory cycle.
REQ-013 Address  output  20  bus address, stable T1 through T4.
REQ-014 Data_out  output  8, Data_oe  output  1  write data and its drive enable.
REQ-015 ack[1:0], err[1:0], rdata  output  2/2/8  one-cycle completion/abort pulse per requester; read data.

Function
REQ-016 States SHALL be IDLE, T1, T2, T3, T4, one-hot encoded.
REQ-017 IDLE: if any req, grant one requester via round-robin, latch its addr/we/iom/wdata, go to T1; else stay IDLE.
REQ-018 Round-robin: when both request, grant the one not granted last; pointer resets to favour requester 0.
REQ-019 T1: ALE=1, Address/IOM driven from latched values; always go to T2.
REQ-020 T2: RD=0 for reads or WR=0 for writes; Data_oe=1 for writes from T2 through T4; go to T3.
REQ-021 T3: strobe held; if READY=1 sample Data_in into rdata (reads) and go to T4; if READY=0 increment wait counter and stay.
REQ-022 When the wait counter reaches MAX_WAIT with READY still 0, go to T4 and flag an abort; rdata unchanged.
REQ-023 T4: RD=WR=1; pulse ack[g] (normal) or err[g] (abort) for exactly this cycle; return to IDLE.
REQ-024 Minimum cycle: req sampled in IDLE at edge n, ack high in cycle n+4 (T1..T4); each wait state adds one cycle.
REQ-025 Wait counter is 4 bits, cleared on entry to T1, never wraps.
REQ-026 Only one strobe may be low at any time; RD and WR never both 0.
REQ-027 Requests arriving or dropping after grant do not affect the cycle in progress; the granted cycle completes.
REQ-028 Outside T1..T4: ALE=0, RD=WR=1, Data_oe=0, Address holds last value.

Reset
REQ-029 RESET at any edge, including mid-cycle: state=IDLE, ALE=0, RD=WR=1, IOM=0, Data_oe=0, Address=0, Data_out=0, rdata=0, ack=err=0, RR pointer=0, wait counter=0.
REQ-030 A cycle interrupted by RESET produces no ack or err pulse.

Structure
REQ-031 Shared package mem_bus_pkg SHALL hold the state enum (bus_state_t), MAX_WAIT default, address width 20 and data width 8.
REQ-032 Two-requester round-robin arbitration SHALL be a sub-module rr_arbiter2 (req in, one-hot grant out, pointer update on enable).

Verification
REQ-033 CPU read 0x12345, READY=1, Data_in=0xA5 -> ALE in T1, RD low T2–T3, ack[0] at n+4, rdata=0xA5.
REQ-034 DMA write 0x00FF0 data 0x3C, IOM=1 -> IOM=1, WR low T2–T3, Data_out=0x3C, Data_oe high T2–T4, ack[1] at n+4.
REQ-035 Both req high continuously -> grants alternate 0,1,0,1; no requester granted twice in a row.
REQ-036 READY low 3 cycles in T3 -> ack at n+7; READY never high -> err pulse after 15 wait states, no ack.
REQ-037 RESET asserted during T2 of a read -> next cycle RD=1, state IDLE, no ack/err.
REQ-038 Assert throughout: RD and WR never both 0; ALE high only in T1.
